elevator_floor_ctrl: RTL and testbench
======================================

Name: elevator_floor_ctrl

Overview:
Sequencing controller for the elevator car. It latches floor call requests, schedules car movement with a collective (SCAN) policy, and times travel between floors and door dwell. Its 4-bit current-floor code directly feeds the existing right seven-segment digit driver inputs {A0,B0,C0,D0} (A0 = MSB). It also provides direction, moving, and door status for the status LEDs and the left digit.

Parameters:
NUM_FLOORS, 8, number of served floors (2..16); floor index 0..NUM_FLOORS-1.
TRAVEL_CYCLES, 4, clock cycles per one-floor move (≥2).
DOOR_CYCLES, 3, clock cycles the door stays open after the last hold/reopen (≥2).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
call_req  in  NUM_FLOORS  floor call buttons; any bit high for ≥1 cycle is latched.
door_hold  in  1  door-open button; level-sensitive.
floor_code  out  4  current floor index, binary; drives {A0,B0,C0,D0}.
dir_up  out  1  1 = current/last direction is up.
moving  out  1  high while in MOVE.
door_open  out  1  high while in DOOR.
pending  out  NUM_FLOORS  latched, unserved requests.
arrive  out  1  one-cycle pulse when floor_code changes.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, floor_code 0, dir_up 1, moving 0, door_open 0, pending 0, arrive 0, timer 0.
- Reset mid-operation (MOVE or DOOR): the next edge gives all reset values, and pending requests are discarded. There is no position sensor, so floor returns to 0.
- Request latch: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask is the current-floor bit while in DOOR or on DOOR entry.
  - A current-floor request is never latched while the door is open.
- States: IDLE, MOVE, DOOR. The state register is one-hot or binary; the encoding comes from the package.
- IDLE:
  - call_req or pending bit at the current floor → DOOR on the next edge.
  - Else, if any pending bit above/below the current floor:
    - Keep dir_up if requests exist in that direction; otherwise flip dir_up.
    - Go to MOVE and load timer = TRAVEL_CYCLES-1.
  - Else stay in IDLE.
  - The decision takes exactly one cycle.
- MOVE:
  - Timer decrements each cycle.
  - At timer==0: floor_code ±1 per dir_up, and arrive pulses on the same edge.
  - Then, using the new floor:
    - pending bit set → DOOR.
    - Else, requests remain further in dir_up → reload timer and stay in MOVE.
    - Else → IDLE.
  - Each floor therefore takes exactly TRAVEL_CYCLES cycles.
- DOOR:
  - On entry, load timer = DOOR_CYCLES-1 and clear the floor's pending bit.
  - door_hold high or a current-floor call_req reloads the timer.
  - At timer==0 with no hold → IDLE.
  - door_open is high for DOOR_CYCLES cycles after the last hold/reopen.
- Direction rule: dir_up changes only in IDLE. Requests behind the car wait until no requests remain ahead.
- Bounds: floor_code never goes below 0 or above NUM_FLOORS-1. The scheduler only moves toward set pending bits; an RTL assertion guards this.
- Simultaneous events:
  - A request arriving in the same cycle the car reaches that floor is served (door opens).
  - A request for the floor just passed is latched and served on the return sweep.
- Width: upper floor_code bits are 0 when NUM_FLOORS < 16.
- "Above" and "below" masks are derived combinationally from floor_code. Outputs are registered except pending, which is a register itself.

Decomposition:
- Shared package/header elev_pkg:
  - State encodings ST_IDLE, ST_MOVE, ST_DOOR.
  - FLOOR_W = 4.
  - Helper function for the above/below masks.
- One sub-module, elev_timer: loadable down-counter with load, load_val, and done (count==0).
  - Shared by travel and door timing, since only one is active at a time.

Test Plan (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
1. Assert reset 2 cycles, then release → floor_code=0, dir_up=1, moving=0, door_open=0, pending=8'h00, arrive=0.
2. Idle at floor 0, pulse call_req=8'h08 for 1 cycle → pending=8'h08 next edge, moving=1 one cycle later. floor_code steps 1, 2, 3 every 4 cycles with an arrive pulse at each. door_open=1 for 3 cycles, pending=8'h00, then IDLE.
3. Moving up from floor 3 toward 6, pulse call_req bits 5 and 1 → stops at 5 (door), continues to 6 (door), flips dir_up=0 in IDLE, travels to 1. pending ends 8'h00.
4. Idle at floor 2, pulse call_req=8'h04 → door_open=1 on the next edge, pending stays 8'h00, moving stays 0.
5. During DOOR, hold door_hold high 10 cycles → door_open stays 1 throughout and drops exactly 3 cycles after door_hold falls.
6. Assert reset for 1 cycle mid-MOVE between floors 4 and 5 with pending=8'h81 → next edge: floor_code=0, pending=8'h00, moving=0, door_open=0.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator floor controller.
package elev_pkg;

  localparam int FLOOR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  function automatic logic [15:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [15:0] m;
    m = (16'd2 << f) - 16'd1;
    return ~m;
  endfunction

  function automatic logic [15:0] below_mask(input logic [FLOOR_W-1:0] f);
    return (16'd1 << f) - 16'd1;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by travel and door timing.
module elev_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Collective (SCAN) elevator sequencer with travel and door timing.
module elevator_floor_ctrl
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    floor_code,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrive
);

  localparam int TW = 16;
  localparam logic [TW-1:0] TRAV_V = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_V = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

  state_t state, nstate;
  logic [FLOOR_W-1:0] nfloor;
  logic ndir, narrive, load, tdone, up_any, dn_any;
  logic [TW-1:0] load_val;
  logic [15:0] pend16, req16, call16, clr16;

  elev_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .done     (tdone)
  );

  always_comb begin
    pend16   = 16'(pending);
    call16   = 16'(call_req);
    req16    = pend16 | call16;
    up_any   = |(pend16 & above_mask(floor_code));
    dn_any   = |(pend16 & below_mask(floor_code));
    nstate   = state;
    nfloor   = floor_code;
    ndir     = dir_up;
    narrive  = 1'b0;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      ST_IDLE: begin
        if (req16[floor_code]) begin
          nstate   = ST_DOOR;
          load     = 1'b1;
          load_val = DOOR_V;
        end else if (up_any || dn_any) begin
          ndir     = dir_up ? up_any : !dn_any;
          nstate   = ST_MOVE;
          load     = 1'b1;
          load_val = TRAV_V;
        end
      end
      ST_MOVE: begin
        if (tdone) begin
          nfloor  = dir_up ? floor_code + 1'b1 : floor_code - 1'b1;
          narrive = 1'b1;
          if (req16[nfloor]) begin
            nstate   = ST_DOOR;
            load     = 1'b1;
            load_val = DOOR_V;
          end else if (|(req16 & (dir_up ? above_mask(nfloor)
                                         : below_mask(nfloor)))) begin
            load     = 1'b1;
            load_val = TRAV_V;
          end else begin
            nstate = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (door_hold || call16[floor_code]) begin
          load     = 1'b1;
          load_val = DOOR_V;
        end else if (tdone) begin
          nstate = ST_IDLE;
        end
      end
      default: nstate = ST_IDLE;
    endcase
    // Door entry and dwell both suppress the car's own floor request
    clr16 = (nstate == ST_DOOR) ? (16'd1 << nfloor) : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      floor_code <= '0;
      dir_up     <= 1'b1;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      pending    <= '0;
      arrive     <= 1'b0;
    end else begin
      state      <= nstate;
      floor_code <= nfloor;
      dir_up     <= ndir;
      moving     <= (nstate == ST_MOVE);
      door_open  <= (nstate == ST_DOOR);
      pending    <= (pending | call_req) & ~clr16[NUM_FLOORS-1:0];
      arrive     <= narrive;
    end
  end

  a_bounds: assert property (@(posedge clk) disable iff (reset)
    (state == ST_MOVE && tdone) |->
      (dir_up ? floor_code != TOP : floor_code != '0));

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Directed scoreboard bench for elevator_floor_ctrl (8 floors, 4/3 cycles).
module tb_elevator_floor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] call_req;
  logic       door_hold;
  logic [3:0] floor_code;
  logic       dir_up, moving, door_open, arrive;
  logic [7:0] pending;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  elevator_floor_ctrl #(
    .NUM_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .call_req   (call_req),
    .door_hold  (door_hold),
    .floor_code (floor_code),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .pending    (pending),
    .arrive     (arrive)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic [3:0] f, input logic d,
      input logic m, input logic o, input logic a, input logic [7:0] p);
    return {f, d, m, o, a, p};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [15:0] o;
    o = {floor_code, dir_up, moving, door_open, arrive, pending};
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%h", o);
    end else begin
      e = q.pop_front();
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    call_req = '0;
    door_hold = 1'b0;
    push("reset", ev(0, 1, 0, 0, 0, 8'h00));
    tick(2);
    pop_cmp();
    reset = 1'b0;

    // Single call to floor 3 from floor 0
    push("t2_latch", ev(0, 1, 0, 0, 0, 8'h08));
    push("t2_move",  ev(0, 1, 1, 0, 0, 8'h08));
    push("t2_f1",    ev(1, 1, 1, 0, 1, 8'h08));
    push("t2_f2",    ev(2, 1, 1, 0, 1, 8'h08));
    push("t2_door",  ev(3, 1, 0, 1, 1, 8'h00));
    push("t2_dlast", ev(3, 1, 0, 1, 0, 8'h00));
    push("t2_idle",  ev(3, 1, 0, 0, 0, 8'h00));
    call_req = 8'h08;
    tick(1); call_req = '0; pop_cmp();
    tick(1); pop_cmp();
    tick(4); pop_cmp();
    tick(4); pop_cmp();
    tick(4); pop_cmp();
    tick(2); pop_cmp();
    tick(1); pop_cmp();

    // Up sweep 3->5->6, then reverse to 1
    push("t3_latch", ev(3, 1, 1, 0, 0, 8'h62));
    push("t3_f5",    ev(5, 1, 0, 1, 1, 8'h42));
    push("t3_f6",    ev(6, 1, 0, 1, 1, 8'h02));
    push("t3_flip",  ev(6, 0, 1, 0, 0, 8'h02));
    push("t3_f1",    ev(1, 0, 0, 1, 1, 8'h00));
    push("t3_idle",  ev(1, 0, 0, 0, 0, 8'h00));
    call_req = 8'h40;
    tick(1); call_req = '0;
    tick(1); call_req = 8'h22;
    tick(1); call_req = '0; pop_cmp();
    tick(7);  pop_cmp();
    tick(8);  pop_cmp();
    tick(4);  pop_cmp();
    tick(20); pop_cmp();
    tick(3);  pop_cmp();

    // Go to floor 2, then call at current floor
    push("t4_move",  ev(1, 1, 1, 0, 0, 8'h04));
    push("t4_f2",    ev(2, 1, 0, 1, 1, 8'h00));
    push("t4_idle",  ev(2, 1, 0, 0, 0, 8'h00));
    push("t4_here",  ev(2, 1, 0, 1, 0, 8'h00));
    call_req = 8'h04;
    tick(1); call_req = '0;
    tick(1); pop_cmp();
    tick(4); pop_cmp();
    tick(3); pop_cmp();
    call_req = 8'h04;
    tick(1); call_req = '0; pop_cmp();

    // Door hold for 10 cycles
    for (int i = 0; i < 10; i++) push("t5_hold", ev(2, 1, 0, 1, 0, 8'h00));
    push("t5_rel1", ev(2, 1, 0, 1, 0, 8'h00));
    push("t5_rel2", ev(2, 1, 0, 1, 0, 8'h00));
    push("t5_close", ev(2, 1, 0, 0, 0, 8'h00));
    door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pop_cmp();
    end
    door_hold = 1'b0;
    tick(1); pop_cmp();
    tick(1); pop_cmp();
    tick(1); pop_cmp();

    // Reset mid-move between 4 and 5 with pending 0x81
    push("t6_move",  ev(2, 1, 1, 0, 0, 8'h80));
    push("t6_f4",    ev(4, 1, 1, 0, 1, 8'h80));
    push("t6_p81",   ev(4, 1, 1, 0, 0, 8'h81));
    push("t6_reset", ev(0, 1, 0, 0, 0, 8'h00));
    push("t6_after", ev(0, 1, 0, 0, 0, 8'h00));
    call_req = 8'h80;
    tick(1); call_req = '0;
    tick(1); pop_cmp();
    tick(8); pop_cmp();
    call_req = 8'h01;
    tick(1); call_req = '0; pop_cmp();
    reset = 1'b1;
    tick(1); pop_cmp();
    reset = 1'b0;
    tick(2); pop_cmp();

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
